mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the core, beside dmem.
- Consumes the core's store stream: MemWrite, the ALU result address and WriteData.
- Queues bytes in a small FIFO and serialises them 8N1 on a single tx line.
- Exposes a readable status word; the top level muxes it onto ReadData when sel is high.

---
 rtl/mmio_uart_pkg.sv | 21 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the serialiser state encoding, the register offsets inside the
// 8-byte window and the bit positions of the STATUS word.
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int ST_ACTIVE   = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_OVERFLOW = 3;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, reset     : clock and asynchronous active-high reset (control only)
//   push, din      : write request and data; accepted when not full, or when
//                    full but a pop happens on the same edge
//   pop, dout      : read request; dout always shows the current head
//   full, empty    : decoded from the registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop on the same edge frees the slot being written, so a full FIFO
  // can still take a byte when it is drained at the same time.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   we, a, wd  : core store stream (MemWrite, DataAdr, WriteData)
//   rd         : register read data for the decoded address, 0 outside window
//   sel        : address falls inside the 8-byte register window
//   tx         : registered serial line, idle high
//   busy       : a frame is in flight or bytes are still queued
// Register window:
//   +0 TXDATA : write queues wd[7:0], reads 0
//   +4 STATUS : reads {28'b0, overflow, full, empty, active}; write clears overflow
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  logic [CW-1:0] cyc;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        overflow;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        pop;
  logic        cyc_end;
  logic        push_req;
  logic        status_wr;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{a[1:0], wd[31:8]};

  assign sel       = (a[31:3] == BASE_ADDR[31:3]);
  assign push_req  = we & sel & (a[2] == TXDATA_OFS[2]);
  assign status_wr = we & sel & (a[2] == STATUS_OFS[2]);

  assign cyc_end = (cyc == CYC_LAST);

  // The head byte is taken either from IDLE or at the last cycle of STOP,
  // the latter giving back-to-back frames with no idle gap.
  assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & cyc_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status                = '0;
    status[ST_ACTIVE]     = (state != IDLE);
    status[ST_EMPTY]      = fifo_empty;
    status[ST_FULL]       = fifo_full;
    status[ST_OVERFLOW]   = overflow;
  end

  assign rd   = (sel && (a[2] == STATUS_OFS[2])) ? status : '0;
  assign busy = (state != IDLE) | ~fifo_empty;

  // A dropped byte and a clearing STATUS write on the same edge leave the
  // flag set, so software never misses a loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req & fifo_full & ~pop) begin
      overflow <= 1'b1;
    end else if (status_wr) begin
      overflow <= 1'b0;
    end
  end

  // Shift register: loaded on pop, moved right at each bit boundary so that
  // bit 0 always holds the next data bit to drive.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo_dout;
    end else if (cyc_end && ((state == START) || (state == DATA))) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cyc     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cyc <= '0;
          if (!fifo_empty) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cyc_end) begin
            cyc     <= '0;
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DATA: begin
          if (cyc_end) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift[0];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        STOP: begin
          if (cyc_end) begin
            cyc <= '0;
            if (!fifo_empty) begin
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cyc   <= '0;
        end
      endcase
    end
  end

endmodule
